// File: rtl/efpga_cfg_loader_if.sv
// Wishbone slave bus bundle between the user-area bus and the config loader.
interface efpga_cfg_loader_if;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output stb, cyc, we, sel, adr, dat_w, input ack, dat_r);
    modport slave  (input stb, cyc, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/efpga_cfg_loader.sv
// eFPGA configuration sequencer: Wishbone-written bitstream words are buffered in a FIFO
// and paced out to the fabric config port, holding the fabric in reset while loading.
module efpga_cfg_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          STROBE_GAP = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    efpga_cfg_loader_if.slave wbs,
    output logic [31:0]       cfg_data_o,
    output logic              cfg_strobe_o,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    output logic              fabric_rst_no
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    GAP_LAST   = 4'((STROBE_GAP > 0) ? STROBE_GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GAP, ST_DONE} state_t;
    state_t state_reg, state_next;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [15:0]   count_reg, sent_reg, sent_next;
    logic          err_reg, err_next;
    logic [3:0]    gap_reg, gap_next;
    logic          ack_reg;
    logic [31:0]   rdata_reg;
    logic [31:0]   cfg_data_reg;
    logic          strobe_reg;

    logic          hit, active, fifo_full, fifo_empty, stall, accept;
    logic          ctrl_wr, count_wr, data_wr, start, abort;
    logic          push, pop, flush;
    logic [1:0]    offset;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign unused_bits = ^{wbs.sel, wbs.adr[1:0]};

    assign offset     = wbs.adr[3:2];
    assign hit        = wbs.stb & wbs.cyc & (wbs.adr[31:4] == BASE_ADDR[31:4]);
    assign active     = (state_reg == ST_LOAD) || (state_reg == ST_GAP);
    assign fifo_full  = (level_reg == FULL_LEVEL);
    assign fifo_empty = (level_reg == '0);

    // A full FIFO holds off a DATA write; a pop in the same cycle is not looked at,
    // so the write is taken on the following cycle at the earliest.
    assign stall  = wbs.we & (offset == 2'd2) & active & fifo_full;
    assign accept = hit & ~ack_reg & ~stall;

    assign ctrl_wr  = accept & wbs.we & (offset == 2'd0);
    assign count_wr = accept & wbs.we & (offset == 2'd1);
    assign data_wr  = accept & wbs.we & (offset == 2'd2);
    assign abort    = ctrl_wr & wbs.dat_w[1];
    assign start    = ctrl_wr & wbs.dat_w[0] & ~wbs.dat_w[1];

    always_comb begin
        state_next = state_reg;
        sent_next  = sent_reg;
        err_next   = err_reg;
        gap_next   = gap_reg;
        pop        = 1'b0;
        flush      = 1'b0;
        push       = data_wr & active;
        if (data_wr && !active) begin
            err_next = 1'b1;
        end
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    flush      = 1'b1;
                    sent_next  = 16'd0;
                    err_next   = 1'b0;
                    state_next = (count_reg == 16'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    sent_next = sent_reg + 16'd1;
                    if (sent_reg + 16'd1 == count_reg) begin
                        state_next = ST_DONE;
                    end else if (STROBE_GAP > 0) begin
                        state_next = ST_GAP;
                        gap_next   = 4'd0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_LOAD;
                end else begin
                    gap_next = gap_reg + 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides everything, including a pop that would otherwise happen now.
        if (abort) begin
            state_next = ST_IDLE;
            flush      = 1'b1;
            pop        = 1'b0;
            sent_next  = sent_reg;
            err_next   = 1'b1;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (offset)
            2'd1:    rd_mux = {16'd0, count_reg};
            2'd3:    rd_mux = {sent_reg, 8'(level_reg), 5'd0, err_reg, cfg_done_o, cfg_busy_o};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_reg    <= ST_IDLE;
            sent_reg     <= 16'd0;
            err_reg      <= 1'b0;
            gap_reg      <= 4'd0;
            count_reg    <= 16'd0;
            ack_reg      <= 1'b0;
            rdata_reg    <= 32'd0;
            strobe_reg   <= 1'b0;
            cfg_data_reg <= 32'd0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sent_reg   <= sent_next;
            err_reg    <= err_next;
            gap_reg    <= gap_next;
            ack_reg    <= accept;
            rdata_reg  <= (accept && !wbs.we) ? rd_mux : 32'd0;
            strobe_reg <= pop;
            if (count_wr && !active) begin
                count_reg <= wbs.dat_w[15:0];
            end
            if (pop) begin
                cfg_data_reg <= fifo_mem[rd_ptr_reg];
            end
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
                case ({push, pop})
                    2'b10:   level_reg <= level_reg + LW'(1);
                    2'b01:   level_reg <= level_reg - LW'(1);
                    default: level_reg <= level_reg;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wbs.dat_w;
        end
    end

    assign wbs.ack       = ack_reg;
    assign wbs.dat_r     = rdata_reg;
    assign cfg_data_o    = cfg_data_reg;
    assign cfg_strobe_o  = strobe_reg;
    assign cfg_busy_o    = active;
    assign cfg_done_o    = (state_reg == ST_DONE);
    assign fabric_rst_no = ~active;
endmodule

// File: tb/tb_efpga_cfg_loader.sv
// Directed bench: a default instance plus a long-gap instance used to fill the FIFO.
module tb_efpga_cfg_loader;
    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_COUNT  = 32'h3000_0004;
    localparam logic [31:0] A_DATA   = 32'h3000_0008;
    localparam logic [31:0] A_STATUS = 32'h3000_000C;
    localparam logic [31:0] A_MISS   = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_stb = 1'b0, m_we = 1'b0, use_slow = 1'b0;
    logic [31:0] m_adr = 32'd0, m_dat = 32'd0;
    int          vectors = 0, miscompares = 0;
    int          cyc_n = 0;

    logic [31:0] f_data, s_data;
    logic        f_strobe, f_busy, f_done, f_frst;
    logic        s_strobe, s_busy, s_done, s_frst;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic [31:0] f_q[$];
    int          f_t[$];
    logic [31:0] s_q[$];

    efpga_cfg_loader_if bus_f ();
    efpga_cfg_loader_if bus_s ();

    assign bus_f.stb   = m_stb & ~use_slow;
    assign bus_f.cyc   = m_stb & ~use_slow;
    assign bus_f.we    = m_we;
    assign bus_f.sel   = 4'hF;
    assign bus_f.adr   = m_adr;
    assign bus_f.dat_w = m_dat;
    assign bus_s.stb   = m_stb & use_slow;
    assign bus_s.cyc   = m_stb & use_slow;
    assign bus_s.we    = m_we;
    assign bus_s.sel   = 4'hF;
    assign bus_s.adr   = m_adr;
    assign bus_s.dat_w = m_dat;
    assign bus_ack     = use_slow ? bus_s.ack : bus_f.ack;
    assign bus_rdata   = use_slow ? bus_s.dat_r : bus_f.dat_r;

    efpga_cfg_loader dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus_f),
        .cfg_data_o(f_data), .cfg_strobe_o(f_strobe), .cfg_busy_o(f_busy),
        .cfg_done_o(f_done), .fabric_rst_no(f_frst)
    );

    efpga_cfg_loader #(.STROBE_GAP(15)) dut_slow (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus_s),
        .cfg_data_o(s_data), .cfg_strobe_o(s_strobe), .cfg_busy_o(s_busy),
        .cfg_done_o(s_done), .fabric_rst_no(s_frst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (f_strobe) begin
            f_q.push_back(f_data);
            f_t.push_back(cyc_n);
        end
        if (s_strobe) s_q.push_back(s_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input bit slow, input logic [31:0] a, input bit w, input logic [31:0] d,
                       input int budget, output logic [31:0] q, output bit acked, output int waits);
        @(negedge clk);
        use_slow = slow; m_adr = a; m_we = w; m_dat = d; m_stb = 1'b1;
        acked = 1'b0; q = 'x; waits = 0;
        while (!acked && waits < budget) begin
            @(negedge clk);
            waits++;
            if (bus_ack) begin
                acked = 1'b1;
                q = bus_rdata;
            end
        end
        m_stb = 1'b0; m_we = 1'b0;
    endtask

    task automatic wr(input bit slow, input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] q; bit ok; int n;
        bus(slow, a, 1'b1, d, 32, q, ok, n);
        check(tag, 32'(ok), 32'd1);
        $display("write %s adr=%08h dat=%08h acked=%0d waits=%0d", tag, a, d, ok, n);
    endtask

    task automatic rd(input bit slow, input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] q; bit ok; int n;
        bus(slow, a, 1'b0, 32'd0, 32, q, ok, n);
        check(tag, q, exp);
        $display("read  %s adr=%08h dat=%08h acked=%0d", tag, a, q, ok);
    endtask

    task automatic wait_fast(input int target, input int budget, input string tag);
        int n = 0;
        while (f_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(f_q.size()), 32'(target));
    endtask

    initial begin
        logic [31:0] q;
        bit          ok;
        int          n, base;
        logic [31:0] words [6];
        int          exp_wait [6];

        words = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003,
                  32'hD000_0004, 32'hD000_0005, 32'hD000_0006};
        exp_wait = '{1, 1, 1, 1, 1, 9};

        repeat (3) @(negedge clk);
        check("rst_strobe", 32'(f_strobe), 32'd0);
        check("rst_busy",   32'(f_busy),   32'd0);
        check("rst_done",   32'(f_done),   32'd0);
        check("rst_frst",   32'(f_frst),   32'd1);
        check("rst_data",   f_data,        32'd0);
        check("rst_ack",    32'(bus_f.ack), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a load
        wr(0, A_COUNT, 32'd2, "t1_count");
        wr(0, A_CTRL, 32'd1, "t1_start");
        check("t1_frst_low", 32'(f_frst), 32'd0);
        wr(0, A_DATA, 32'h0000_0011, "t1_data");
        wait_fast(1, 20, "t1_strobe_cnt");
        rst_n = 1'b0;
        @(negedge clk);
        check("t1_busy",   32'(f_busy),   32'd0);
        check("t1_frst",   32'(f_frst),   32'd1);
        check("t1_strobe", 32'(f_strobe), 32'd0);
        check("t1_done",   32'(f_done),   32'd0);
        rst_n = 1'b1;
        rd(0, A_STATUS, 32'd0, "t1_status");

        // Three words, strobes spaced by the gap
        base = f_q.size();
        wr(0, A_COUNT, 32'd3, "t2_count");
        wr(0, A_CTRL, 32'd1, "t2_start");
        wr(0, A_DATA, 32'h0000_00A1, "t2_d0");
        wr(0, A_DATA, 32'h0000_00B2, "t2_d1");
        wr(0, A_DATA, 32'h0000_00C3, "t2_d2");
        wait_fast(base + 3, 40, "t2_strobe_cnt");
        if (f_q.size() >= base + 3) begin
            check("t2_w0", f_q[base],     32'h0000_00A1);
            check("t2_w1", f_q[base + 1], 32'h0000_00B2);
            check("t2_w2", f_q[base + 2], 32'h0000_00C3);
            check("t2_gap01", 32'(f_t[base + 1] - f_t[base]),     32'd3);
            check("t2_gap12", 32'(f_t[base + 2] - f_t[base + 1]), 32'd3);
        end
        check("t2_done", 32'(f_done), 32'd1);
        check("t2_frst", 32'(f_frst), 32'd1);
        check("t2_busy", 32'(f_busy), 32'd0);
        rd(0, A_STATUS, 32'h0003_0002, "t2_status");

        // Back-to-back words into a slowly drained FIFO
        wr(1, A_COUNT, 32'd8, "t3_count");
        wr(1, A_CTRL, 32'd1, "t3_start");
        for (int i = 0; i < 6; i++) begin
            bus(1, A_DATA, 1'b1, words[i], 32, q, ok, n);
            check($sformatf("t3_ack_d%0d", i), 32'(ok), 32'd1);
            check($sformatf("t3_wait_d%0d", i), 32'(n), 32'(exp_wait[i]));
            $display("write t3_d%0d dat=%08h waits=%0d", i, words[i], n);
        end
        rd(1, A_STATUS, 32'h0002_0401, "t3_status_full");
        n = 0;
        while (s_q.size() < 6 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("t3_strobe_cnt", 32'(s_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < s_q.size()) check($sformatf("t3_w%0d", i), s_q[i], words[i]);
        end
        rd(1, A_STATUS, 32'h0006_0001, "t3_status_end");
        wr(1, A_COUNT, 32'd3, "t3_count_busy");
        rd(1, A_COUNT, 32'd8, "t3_count_kept");

        // Abort part way through
        base = f_q.size();
        wr(0, A_COUNT, 32'd5, "t4_count");
        wr(0, A_CTRL, 32'd1, "t4_start");
        wr(0, A_DATA, 32'h0000_0044, "t4_d0");
        wr(0, A_DATA, 32'h0000_0055, "t4_d1");
        wait_fast(base + 2, 30, "t4_strobe_cnt");
        wr(0, A_CTRL, 32'd2, "t4_abort");
        check("t4_frst", 32'(f_frst), 32'd1);
        check("t4_busy", 32'(f_busy), 32'd0);
        rd(0, A_STATUS, 32'h0002_0004, "t4_status");
        wr(0, A_DATA, 32'h0000_0066, "t4_data_idle");
        wr(0, A_CTRL, 32'd3, "t4_abort_start");
        check("t4_busy_after", 32'(f_busy), 32'd0);
        rd(0, A_STATUS, 32'h0002_0004, "t4_status2");
        repeat (8) @(negedge clk);
        check("t4_no_strobe", 32'(f_q.size()), 32'(base + 2));
        if (f_q.size() >= base + 2) begin
            check("t4_w0", f_q[base],     32'h0000_0044);
            check("t4_w1", f_q[base + 1], 32'h0000_0055);
        end

        // Zero-length load
        base = f_q.size();
        wr(0, A_COUNT, 32'd0, "t5_count");
        wr(0, A_CTRL, 32'd1, "t5_start");
        check("t5_done", 32'(f_done), 32'd1);
        check("t5_busy", 32'(f_busy), 32'd0);
        rd(0, A_STATUS, 32'h0000_0002, "t5_status");
        repeat (5) @(negedge clk);
        check("t5_no_strobe", 32'(f_q.size()), 32'(base));

        // Address miss and COUNT readback
        bus(0, A_MISS, 1'b0, 32'd0, 16, q, ok, n);
        check("t6_miss_ack", 32'(ok), 32'd0);
        $display("read  t6_miss adr=%08h acked=%0d waits=%0d", A_MISS, ok, n);
        wr(0, A_COUNT, 32'h0000_BEEF, "t6_count");
        rd(0, A_COUNT, 32'h0000_BEEF, "t6_count_rd");
        rd(0, A_CTRL, 32'd0, "t6_ctrl_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
